spi_segment_mux_controller: RTL and testbench

//  SPI-slave-controlled driver for a multiplexed 7-segment display with NUM_DIGITS digits.
//  An SPI master writes and reads digit and control registers with 16-bit frames.
//  The block scans the digits with per-digit time slots and a 16-step brightness PWM.
//  It optionally hex-decodes nibbles to segment patterns.
//  It sits between the chip pins (ui_in/uio) and the display, and succeeds the single-channel SPI slave.

---
 rtl/spi_segment_mux_controller_if.sv | 30 +++
 rtl/spi_segment_mux_controller.sv | 192 +++++++++++++++++++
 tb/tb_spi_segment_mux_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_segment_mux_controller_if.sv
// rtl/spi_segment_mux_controller_if.sv - SPI pin and display drive bundle
// Purpose: groups the SPI pins and the display outputs of the segment mux controller.
// Signals:
//   sck, cs_n, mosi   SPI clock, chip select (active low) and data in, from the master side
//   miso, miso_oe     SPI data out and its output enable, from the controller
//   seg[7:0]          segment drive, [6:0]=gfedcba, [7]=dp
//   dig_en            one-hot (or zero) digit enable
//   frame_err         one-clk pulse on an aborted frame
interface spi_segment_mux_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  sck;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  frame_err;

  modport master (
    output sck, cs_n, mosi,
    input  miso, miso_oe, seg, dig_en, frame_err
  );

  modport slave (
    input  sck, cs_n, mosi,
    output miso, miso_oe, seg, dig_en, frame_err
  );
endinterface

// File: rtl/spi_segment_mux_controller.sv
// rtl/spi_segment_mux_controller.sv - SPI-slave controlled multiplexed 7-segment driver
// Purpose: 16-bit SPI frames write/read digit registers and CTRL; a scan engine
//   time-multiplexes the digits with a 16-step brightness PWM and optional hex decode.
// Ports:
//   clk   system clock (rising edge)
//   rst   synchronous active-high reset
//   bus   slave modport: sck/cs_n/mosi in; miso/miso_oe/seg/dig_en/frame_err out
module spi_segment_mux_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter bit CPOL       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_segment_mux_controller_if.slave bus
);
  localparam int PRE = SCAN_DIV / 16;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [6:0] CTRL_ADDR = 7'h10;

  // Synchronisers plus one delayed copy for edge detection.
  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_q, cs_q;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_lead, sck_trail, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= {2{CPOL}};
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_q     <= CPOL;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], bus.sck};
      cs_sync   <= {cs_sync[0], bus.cs_n};
      mosi_sync <= {mosi_sync[0], bus.mosi};
      sck_q     <= sck_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sck_s     = sck_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sck_lead  = (sck_s != sck_q) && (sck_s != CPOL);
  assign sck_trail = (sck_s != sck_q) && (sck_s == CPOL);
  assign cs_fall   = cs_q && !cs_s;
  assign cs_rise   = !cs_q && cs_s;

  logic [7:0]  digit_reg [NUM_DIGITS];
  logic [7:0]  ctrl;
  logic [1:0]  state;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] sh_next;
  logic [7:0]  tx;
  logic [7:0]  rd_data;
  logic        miso_r, miso_oe_r, frame_err_r;

  assign sh_next = {shreg[14:0], mosi_s};

  // Read data for the address formed once the 8th bit lands in sh_next[6:0].
  always_comb begin
    rd_data = 8'h00;
    if (sh_next[6:0] == CTRL_ADDR)
      rd_data = ctrl;
    else if (int'(sh_next[6:0]) < NUM_DIGITS)
      rd_data = digit_reg[sh_next[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx          <= '0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      frame_err_r <= 1'b0;
      ctrl        <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
    end else begin
      frame_err_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            tx        <= '0;
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            miso_oe_r <= 1'b0;
            miso_r    <= 1'b0;
            state     <= S_COMMIT;
          end else if (sck_lead) begin
            shreg <= sh_next;
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
            // Eighth bit: R/W and ADDR are complete, latch the read value.
            if (bit_cnt == 5'd7) tx <= sh_next[7] ? rd_data : 8'h00;
          end else if (sck_trail) begin
            if (bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
              miso_r <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end else begin
              miso_r <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          if (bit_cnt == 5'd16) begin
            if (!shreg[15]) begin
              if (shreg[14:8] == CTRL_ADDR)
                ctrl <= shreg[7:0];
              else if (int'(shreg[14:8]) < NUM_DIGITS)
                digit_reg[shreg[8 +: IW]] <= shreg[7:0];
            end
          end else begin
            frame_err_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scan engine: prescaler gives the PWM phase, phase wrap advances the digit.
  logic [PW-1:0]         pre_cnt;
  logic [3:0]            phase;
  logic [IW-1:0]         idx;
  logic [7:0]            cur;
  logic [6:0]            font;
  logic [7:0]            pattern;
  logic                  lit;
  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] dig_en_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
    end else if (pre_cnt == PW'(PRE - 1)) begin
      pre_cnt <= '0;
      phase   <= phase + 4'd1;
      if (phase == 4'd15)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_comb begin
    cur = digit_reg[idx];
    case (cur[3:0])
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
    pattern = ctrl[1] ? {cur[7], font} : cur;
    lit     = ctrl[0] && (phase <= ctrl[7:4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r    <= '0;
      dig_en_r <= '0;
    end else begin
      seg_r    <= lit ? pattern : 8'h00;
      dig_en_r <= lit ? (NUM_DIGITS'(1) << idx) : '0;
    end
  end

  assign bus.seg       = seg_r;
  assign bus.dig_en    = dig_en_r;
  assign bus.miso      = miso_r;
  assign bus.miso_oe   = miso_oe_r;
  assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_spi_segment_mux_controller.sv
// tb/tb_spi_segment_mux_controller.sv - self-checking bench for spi_segment_mux_controller
`timescale 1ns/1ps
module tb_spi_segment_mux_controller;
  localparam int ND = 4;
  localparam int SD = 64;
  localparam int SLOT_PH = SD / 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_segment_mux_controller_if #(.NUM_DIGITS(ND)) bus ();

  spi_segment_mux_controller #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .CPOL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] m_digit [ND];
  logic [7:0] m_ctrl;
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit skip = 1'b0;

  // Rising edges seen with rst low since the last reset edge, and frame_err pulses.
  int cyc = 0;
  int ferr_cnt = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference display state: after cyc edges the outputs show scan tick cyc-1.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!skip) begin
        logic [7:0]    es;
        logic [ND-1:0] ed;
        int t, d, ph;
        es = 8'h00;
        ed = '0;
        if (cyc > 0) begin
          t  = cyc - 1;
          d  = (t / SD) % ND;
          ph = (t % SD) / SLOT_PH;
          if (m_ctrl[0] && ph <= int'(m_ctrl[7:4])) begin
            ed = ND'(1) << d;
            es = m_ctrl[1] ? {m_digit[d][7], font[m_digit[d][3:0]]} : m_digit[d];
          end
        end
        check("model_seg", {24'h0, bus.seg}, {24'h0, es});
        check("model_dig_en", {28'h0, bus.dig_en}, {28'h0, ed});
      end
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    check("miso_oe_idle", {31'h0, bus.miso_oe}, 32'h0);
    bus.cs_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = (i < 16) ? w[15 - i] : 1'b0;
      half();
      bus.sck = 1'b1;
      if (i >= 8 && i < 16) rx[15 - i] = bus.miso;
      if (i == 4) check("miso_oe_active", {31'h0, bus.miso_oe}, 32'h1);
      half();
      bus.sck = 1'b0;
    end
    half();
    bus.cs_n = 1'b1;
    skip = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits == 16 && !w[15]) begin
      if (w[14:8] == 7'h10) m_ctrl = w[7:0];
      else if (int'(w[14:8]) < ND) m_digit[w[9:8]] = w[7:0];
    end
    check("miso_oe_release", {31'h0, bus.miso_oe}, 32'h0);
    skip = 1'b0;
  endtask

  task automatic wait_dig(input logic [ND-1:0] v, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.dig_en == v) ok = 1'b1;
    end
    check("wait_dig_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_next(input logic [ND-1:0] prev, input int budget, output logic [ND-1:0] cur);
    bit ok;
    ok  = 1'b0;
    cur = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.dig_en != '0 && bus.dig_en != prev) begin
        ok  = 1'b1;
        cur = bus.dig_en;
      end
    end
    check("wait_next_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic count_on(output int n);
    n = 0;
    for (int i = 0; i < ND * SD; i++) begin
      @(negedge clk);
      if (bus.dig_en != '0) n++;
    end
  endtask

  initial begin
    logic [7:0]    rx;
    logic [ND-1:0] cur, prev;
    logic [ND-1:0] exp_order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int n, ferr0;

    bus.sck = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    m_ctrl = 8'h00;
    for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_seg", {24'h0, bus.seg}, 32'h0);
    check("rst_dig_en", {28'h0, bus.dig_en}, 32'h0);
    check("rst_miso", {31'h0, bus.miso}, 32'h0);
    check("rst_miso_oe", {31'h0, bus.miso_oe}, 32'h0);
    check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    rst = 1'b0;
    fork
      compare_loop();
    join_none

    // Hex decode, full brightness.
    spi_frame(16'h10F3, 16, rx);
    spi_frame(16'h0005, 16, rx);
    wait_dig(4'b0001, 2 * ND * SD);
    check("t1_digit0_hex5", {24'h0, bus.seg}, 32'h6D);
    for (int d = 1; d < ND; d++) begin
      wait_dig(ND'(1) << d, 2 * ND * SD);
      check("t1_digit_hex0", {24'h0, bus.seg}, 32'h3F);
    end

    // Raw mode, B=0, slot order.
    spi_frame(16'h1001, 16, rx);
    spi_frame(16'h02A5, 16, rx);
    wait_dig(4'b0001, 2 * ND * SD);
    prev = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      wait_next(prev, 2 * SD, cur);
      check("t2_slot_order", {28'h0, cur}, {28'h0, exp_order[k]});
      if (cur == 4'b0100) check("t2_raw_a5", {24'h0, bus.seg}, 32'hA5);
      prev = cur;
    end

    // Brightness duty over one full scan frame.
    count_on(n);
    check("t3_b0_on", n, 32'd16);
    spi_frame(16'h10F1, 16, rx);
    count_on(n);
    check("t3_b15_on", n, 32'd256);
    spi_frame(16'h1071, 16, rx);
    count_on(n);
    check("t3_b7_on", n, 32'd128);

    // Readback.
    spi_frame(16'h013C, 16, rx);
    spi_frame(16'h8100, 16, rx);
    check("t4_read_digit1", {24'h0, rx}, 32'h3C);
    spi_frame(16'h9000, 16, rx);
    check("t4_read_ctrl", {24'h0, rx}, 32'h71);

    // Short/long frames and unknown address.
    ferr0 = ferr_cnt;
    spi_frame(16'h0077, 15, rx);
    check("t5_ferr_15", ferr_cnt, ferr0 + 1);
    spi_frame(16'h0177, 17, rx);
    check("t5_ferr_17", ferr_cnt, ferr0 + 2);
    spi_frame(16'h7FFF, 16, rx);
    spi_frame(16'hFF00, 16, rx);
    check("t5_read_unknown", {24'h0, rx}, 32'h00);
    check("t5_ferr_none", ferr_cnt, ferr0 + 2);
    spi_frame(16'h8100, 16, rx);
    check("t5_digit1_kept", {24'h0, rx}, 32'h3C);

    // Reset mid-frame.
    ferr0 = ferr_cnt;
    bus.cs_n = 1'b0;
    half();
    for (int i = 0; i < 10; i++) begin
      bus.mosi = i[0];
      half();
      bus.sck = 1'b1;
      half();
      bus.sck = 1'b0;
    end
    skip = 1'b1;
    rst = 1'b1;
    m_ctrl = 8'h00;
    for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("t6_seg", {24'h0, bus.seg}, 32'h0);
    check("t6_dig_en", {28'h0, bus.dig_en}, 32'h0);
    check("t6_miso_oe", {31'h0, bus.miso_oe}, 32'h0);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    skip = 1'b0;
    spi_frame(16'h10F3, 16, rx);
    spi_frame(16'h030A, 16, rx);
    wait_dig(4'b1000, 2 * ND * SD);
    check("t6_digit3_hexa", {24'h0, bus.seg}, 32'h77);
    check("t6_no_ferr", ferr_cnt, ferr0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
